// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch requester, data requester and memory-side signals of the
// unified-memory arbiter.
//   slave  : arbiter side. It takes requests and memory ready/rdata, and it
//            drives acks, read data, memory fields and stall.
//   master : environment side. It covers the requesters and the memory.
// Parameters: ADDR_WIDTH, DATA_WIDTH (byte enables are DATA_WIDTH/8 bits).
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // fetch port
   logic                    if_req_i;
   logic [ADDR_WIDTH-1:0]   if_addr_i;
   logic [DATA_WIDTH-1:0]   if_rdata_o;
   logic                    if_ack_o;
   // data (load/store) port
   logic                    d_req_i;
   logic                    d_we_i;
   logic [ADDR_WIDTH-1:0]   d_addr_i;
   logic [DATA_WIDTH-1:0]   d_wdata_i;
   logic [DATA_WIDTH/8-1:0] d_be_i;
   logic [DATA_WIDTH-1:0]   d_rdata_o;
   logic                    d_ack_o;
   // memory port
   logic                    mem_req_o;
   logic                    mem_we_o;
   logic [ADDR_WIDTH-1:0]   mem_addr_o;
   logic [DATA_WIDTH-1:0]   mem_wdata_o;
   logic [DATA_WIDTH/8-1:0] mem_be_o;
   logic [DATA_WIDTH-1:0]   mem_rdata_i;
   logic                    mem_ready_i;
   // pipeline stall
   logic                    stall_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_rdata_o, if_ack_o,
      input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      output d_rdata_o, d_ack_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      input  mem_rdata_i, mem_ready_i,
      output stall_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_rdata_o, if_ack_o,
      output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i,
      input  d_rdata_o, d_ack_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
      output mem_rdata_i, mem_ready_i,
      input  stall_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single-port unified memory between instruction fetch and the
// load/store path.
//   - The winning request is latched in IDLE.
//   - BUSY holds the memory request until mem_ready_i is seen.
//   - DONE returns a one-cycle ack to the owner.
// Data accesses have priority over fetch.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave, carrying the fetch, data, memory and
//            stall signals
//
// Optional feature, macro MEM_ARB_FAIR_EN:
//   defined   : starve counter present. After STARVE_LIMIT consecutive
//               contested data grants, fetch is forced through.
//   undefined : strict data priority.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_WIDTH/8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_gnt_d;       // 1 = data owns the transaction
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [BE_W-1:0]       r_mem_be;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;

   logic w_any_req;
   logic w_pick_d;
   logic w_grant;
   logic w_capture;

   assign w_any_req = bus.if_req_i | bus.d_req_i;

`ifdef MEM_ARB_FAIR_EN
   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
   logic [3:0] r_starve_cnt;

   // Data wins unless fetch is also waiting and has been passed over
   // LIM times in a row.
   assign w_pick_d = bus.d_req_i & ~(bus.if_req_i & (r_starve_cnt == LIM));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_starve_cnt <= '0;
      end else if (w_grant) begin
         if (w_pick_d && bus.if_req_i)
            r_starve_cnt <= (r_starve_cnt == LIM) ? r_starve_cnt : r_starve_cnt + 4'd1;
         else
            r_starve_cnt <= '0;
      end
   end
`else
   assign w_pick_d = bus.d_req_i;
`endif

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM: next state and decoded outputs. mem_req_o and the acks are decoded
   // from the registered state, so reset clears them asynchronously.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant      = 1'b0;
      w_capture    = 1'b0;
      bus.mem_req_o = 1'b0;
      bus.if_ack_o  = 1'b0;
      bus.d_ack_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_grant     = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            bus.mem_req_o = 1'b1;
            if (bus.mem_ready_i) begin
               w_capture   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // No grant here. This gives requesters a cycle to drop their
            // request after the ack.
            bus.if_ack_o = ~r_gnt_d;
            bus.d_ack_o  = r_gnt_d;
            w_state_nxt  = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Transaction fields and read-data registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_gnt_d     <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         if (w_grant) begin
            r_gnt_d <= w_pick_d;
            if (w_pick_d) begin
               r_mem_we    <= bus.d_we_i;
               r_mem_addr  <= bus.d_addr_i;
               r_mem_wdata <= bus.d_wdata_i;
               r_mem_be    <= bus.d_be_i;
            end else begin
               // Fetch is always a full-word read. wdata keeps its old value.
               r_mem_we   <= 1'b0;
               r_mem_addr <= bus.if_addr_i;
               r_mem_be   <= '1;
            end
         end
         // Read data is captured on stores too. That value carries no meaning.
         if (w_capture) begin
            if (r_gnt_d) r_d_rdata  <= bus.mem_rdata_i;
            else         r_if_rdata <= bus.mem_rdata_i;
         end
      end
   end

   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_wdata_o = r_mem_wdata;
   assign bus.mem_be_o    = r_mem_be;
   assign bus.if_rdata_o  = r_if_rdata;
   assign bus.d_rdata_o   = r_d_rdata;

   assign bus.stall_o = (bus.if_req_i & ~bus.if_ack_o) | (bus.d_req_i & ~bus.d_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t mk(input logic d, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic [31:0] rd);
      exp_t e;
      e.d = d; e.we = we; e.addr = a; e.wdata = wd; e.be = be; e.rdata = rd;
      return e;
   endfunction

   // Memory contents as a function of address
   function automatic logic [31:0] mdl(input logic [31:0] a);
      return (a == 32'h10) ? 32'h0030_0093 : (a ^ 32'hA5A5_0F0F);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Memory model: ready after wait_cfg wait cycles
   int wait_cfg = 0;
   int wcnt = 0;
   assign bus.mem_ready_i = bus.mem_req_o && (wcnt >= wait_cfg);
   assign bus.mem_rdata_i = mdl(bus.mem_addr_o);
   always @(posedge clk) begin
      if (bus.mem_req_o && !bus.mem_ready_i) wcnt <= wcnt + 1;
      else                                   wcnt <= 0;
   end

   // Scoreboard monitor: fields during BUSY, owner and rdata on ack
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_req_o) begin
            if (exp_q.size() == 0) chk("busy_unexpected", 32'(exp_q.size()), 32'd1);
            else begin
               chk("mem_we",   32'(bus.mem_we_o), 32'(exp_q[0].we));
               chk("mem_addr", bus.mem_addr_o, exp_q[0].addr);
               chk("mem_be",   32'(bus.mem_be_o), 32'(exp_q[0].be));
               if (exp_q[0].d && exp_q[0].we) chk("mem_wdata", bus.mem_wdata_o, exp_q[0].wdata);
            end
         end
         if (bus.if_ack_o || bus.d_ack_o) begin
            if (exp_q.size() == 0) chk("ack_unexpected", 32'(exp_q.size()), 32'd1);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_owner", 32'(bus.d_ack_o), 32'(e.d));
               chk("ack_both",  32'(bus.if_ack_o & bus.d_ack_o), 32'd0);
               if (!(e.d && e.we))
                  chk("ack_rdata", e.d ? bus.d_rdata_o : bus.if_rdata_o, e.rdata);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until the scoreboard drains. Returns the number of cycles taken.
   task automatic drain(input string tag, input int budget, output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         step();
         cyc++;
      end
      if (exp_q.size() != 0) begin
         chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      bus.if_req_i = 1'b0; bus.if_addr_i = '0;
      bus.d_req_i = 1'b0;  bus.d_we_i = 1'b0; bus.d_addr_i = '0;
      bus.d_wdata_i = '0;  bus.d_be_i = '0;
      #12;
      // Reset values
      chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
      chk("rst_mem_we",  32'(bus.mem_we_o),  32'd0);
      chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
      chk("rst_mem_be",  32'(bus.mem_be_o), 32'd0);
      chk("rst_if_ack",  32'(bus.if_ack_o), 32'd0);
      chk("rst_d_ack",   32'(bus.d_ack_o),  32'd0);
      chk("rst_if_rdata", bus.if_rdata_o, 32'd0);
      chk("rst_d_rdata",  bus.d_rdata_o,  32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1: single fetch, zero wait
      wait_cfg = 0;
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10;
      exp_q.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0030_0093));
      #1 chk("t1_stall_c0", 32'(bus.stall_o), 32'd1);
      step();
      chk("t1_req_c1", 32'(bus.mem_req_o), 32'd1);
      chk("t1_be_c1",  32'(bus.mem_be_o), 32'hF);
      chk("t1_ack_c1", 32'(bus.if_ack_o), 32'd0);
      step();
      chk("t1_ack_c2",   32'(bus.if_ack_o), 32'd1);
      chk("t1_rdata_c2", bus.if_rdata_o, 32'h0030_0093);
      chk("t1_memreq_c2", 32'(bus.mem_req_o), 32'd0);
      bus.if_req_i = 1'b0;
      step();
      chk("t1_idle_c3", {29'd0, bus.mem_req_o, bus.if_ack_o, bus.d_ack_o}, 32'd0);
      step();

      // 2: store with 3 wait cycles
      wait_cfg = 3;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h100;
      bus.d_wdata_i = 32'hDEAD_BEEF; bus.d_be_i = 4'b0011;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 32'h0));
      #1 chk("t2_stall_c0", 32'(bus.stall_o), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("t2_req_c%0d", i),   32'(bus.mem_req_o), 32'd1);
         chk($sformatf("t2_stall_c%0d", i), 32'(bus.stall_o),   32'd1);
         chk($sformatf("t2_ack_c%0d", i),   32'(bus.d_ack_o),   32'd0);
      end
      step();
      chk("t2_ack_c5",   32'(bus.d_ack_o), 32'd1);
      chk("t2_stall_c5", 32'(bus.stall_o), 32'd0);
      bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
      step();
      chk("t2_idle_c6", 32'(bus.mem_req_o), 32'd0);

      // 3: simultaneous requests, data wins, fetch follows
      wait_cfg = 0;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h200;
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h14;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 4'b0011, mdl(32'h200)));
      exp_q.push_back(mk(1'b0, 1'b0, 32'h14,  32'h0, 4'hF,    mdl(32'h14)));
      step();
      step();
      chk("t3_dack_c2",  32'(bus.d_ack_o),  32'd1);
      chk("t3_iack_c2",  32'(bus.if_ack_o), 32'd0);
      chk("t3_stall_c2", 32'(bus.stall_o),  32'd1);
      bus.d_req_i = 1'b0;
      step();
      chk("t3_stall_c3", 32'(bus.stall_o), 32'd1);
      step();
      chk("t3_req_c4", 32'(bus.mem_req_o), 32'd1);
      step();
      chk("t3_iack_c5",  32'(bus.if_ack_o), 32'd1);
      chk("t3_stall_c5", 32'(bus.stall_o),  32'd0);
      bus.if_req_i = 1'b0;
      step();

      // 4: continuous contention
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h300;
      bus.if_req_i = 1'b1; bus.if_addr_i = 32'h18;
      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
         if ((k % 5) == 4) exp_q.push_back(mk(1'b0, 1'b0, 32'h18, 32'h0, 4'hF, mdl(32'h18)));
         else              exp_q.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 4'b0011, mdl(32'h300)));
`else
         exp_q.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 4'b0011, mdl(32'h300)));
`endif
      end
      drain("t4", 60, cyc);
      bus.d_req_i = 1'b0; bus.if_req_i = 1'b0;
      chk("t4_throughput", 32'(cyc), 32'd30);
      step();
      step();

      // 5: reset during the second BUSY cycle
      wait_cfg = 5;
      bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h400;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 4'b0011, mdl(32'h400)));
      step();
      step();
      chk("t5_req_busy2", 32'(bus.mem_req_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_req_rst",  32'(bus.mem_req_o), 32'd0);
      chk("t5_ack_rst",  32'(bus.d_ack_o),   32'd0);
      chk("t5_addr_rst", bus.mem_addr_o, 32'd0);
      step();
      chk("t5_ack_rst2", 32'(bus.d_ack_o), 32'd0);
      wait_cfg = 0;
      rst_n = 1'b1;
      step();
      chk("t5_restart", 32'(bus.mem_req_o), 32'd1);
      drain("t5", 10, cyc);
      bus.d_req_i = 1'b0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
